// File: rtl/program_loader.sv
// Byte-stream bootloader: parses a framed program image, writes 16-bit words into
// instruction memory and holds the cpu in reset until the image checksum verifies.
module program_loader #(
  parameter int unsigned ADDR_WIDTH     = 15,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  start,
  output logic [15:0]           im_d,
  output logic [ADDR_WIDTH-1:0] im_address,
  output logic                  im_we,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           n_q, n_d;
  logic [15:0]           word_cnt_q, word_cnt_d;
  logic [7:0]            hi_q, hi_d;
  logic [7:0]            csum_q, csum_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [15:0]           im_d_q, im_d_d;
  logic [ADDR_WIDTH-1:0] im_address_q, im_address_d;
  logic                  im_we_q, im_we_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  accept;
  logic [15:0]           n_full;

  assign accept = rx_valid && rx_ready_q;
  assign n_full = {n_q[15:8], rx_data};

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    word_cnt_d   = word_cnt_q;
    hi_d         = hi_q;
    csum_d       = csum_q;
    timer_d      = timer_q;
    im_d_d       = im_d_q;
    im_address_d = im_address_q;

    case (state_q)
      HDR_HI: begin
        if (accept) begin
          n_d[15:8] = rx_data;
          timer_d   = '0;
          state_d   = HDR_LO;
        end
      end
      HDR_LO: begin
        if (accept) begin
          n_d[7:0] = rx_data;
          if (33'(n_full) > MAX_WORDS) begin
            state_d = ERROR;
          end else if (n_full == 16'd0) begin
            state_d = CHECK;
          end else begin
            state_d = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (accept) begin
          hi_d    = rx_data;
          csum_d  = 8'(csum_q + rx_data);
          state_d = DATA_LO;
        end
      end
      DATA_LO: begin
        if (accept) begin
          csum_d       = 8'(csum_q + rx_data);
          im_d_d       = {hi_q, rx_data};
          im_address_d = ADDR_WIDTH'(word_cnt_q);
          state_d      = WRITE;
        end
      end
      WRITE: begin
        word_cnt_d = 16'(word_cnt_q + 16'd1);
        state_d    = (word_cnt_q == 16'(n_q - 16'd1)) ? CHECK : DATA_HI;
      end
      CHECK: begin
        if (accept) begin
          state_d = (rx_data == csum_q) ? DONE : ERROR;
        end
      end
      DONE, ERROR: begin
        if (start) begin
          word_cnt_d = '0;
          csum_d     = '0;
          timer_d    = '0;
          state_d    = HDR_HI;
        end
      end
      default: state_d = HDR_HI;
    endcase

    // Inter-byte timeout once a frame has started; WRITE stalls do not count
    if (state_q inside {HDR_LO, DATA_HI, DATA_LO, CHECK}) begin
      if (accept) begin
        timer_d = '0;
      end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = ERROR;
      end else begin
        timer_d = TW'(timer_q + TW'(1));
      end
    end

    im_we_d     = (state_d == WRITE);
    rx_ready_d  = state_d inside {HDR_HI, HDR_LO, DATA_HI, DATA_LO, CHECK};
    busy_d      = state_d inside {HDR_LO, DATA_HI, DATA_LO, WRITE, CHECK};
    done_d      = (state_d == DONE);
    error_d     = (state_d == ERROR);
    cpu_reset_d = (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HDR_HI;
      n_q          <= '0;
      word_cnt_q   <= '0;
      hi_q         <= '0;
      csum_q       <= '0;
      timer_q      <= '0;
      im_d_q       <= '0;
      im_address_q <= '0;
      im_we_q      <= 1'b0;
      rx_ready_q   <= 1'b1;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      word_cnt_q   <= word_cnt_d;
      hi_q         <= hi_d;
      csum_q       <= csum_d;
      timer_q      <= timer_d;
      im_d_q       <= im_d_d;
      im_address_q <= im_address_d;
      im_we_q      <= im_we_d;
      rx_ready_q   <= rx_ready_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign im_d       = im_d_q;
  assign im_address = im_address_q;
  assign im_we      = im_we_q;
  assign rx_ready   = rx_ready_q;
  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed and random frames checked
// against a frame-level reference model of writes and final outcome.
module tb_program_loader;

  localparam int unsigned AW = 15;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          start;
  logic [15:0]   im_d;
  logic [AW-1:0] im_address;
  logic          im_we;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;

  program_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .start(start), .im_d(im_d), .im_address(im_address),
    .im_we(im_we), .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  int         checks = 0;
  int         failures = 0;
  wr_t        seen[$];
  wr_t        exp_q[$];
  logic [7:0] frame[$];
  int         exp_outcome;  // 0 = done, 1 = error, 2 = frame incomplete

  always @(negedge clk) if (im_we === 1'b1) seen.push_back('{addr: im_address, data: im_d});

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a byte and wait (bounded) for the valid/ready handshake
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit rdy;
    int budget;
    if (gap > 0) begin
      rx_valid = 1'b0;
      tick(gap);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    budget   = 0;
    forever begin
      rdy = (rx_ready === 1'b1);
      @(posedge clk);
      #1;
      if (rdy) break;
      budget++;
      if (budget > 20) begin
        checks++;
        failures++;
        $error("FAIL handshake observed=stalled expected=accepted byte=0x%0h", b);
        break;
      end
    end
  endtask

  // Reference: expected writes and outcome derived directly from the frame bytes
  task automatic model();
    int n;
    logic [7:0] sum;
    exp_q = {};
    exp_outcome = 2;
    if (frame.size() < 2) return;
    n = int'({frame[0], frame[1]});
    if (n > (1 << AW)) begin
      exp_outcome = 1;
      return;
    end
    sum = 8'd0;
    for (int i = 0; i < n; i++) begin
      if (frame.size() < 2 * i + 4) return;
      exp_q.push_back('{addr: AW'(i), data: {frame[2 + 2 * i], frame[3 + 2 * i]}});
      sum = 8'(sum + frame[2 + 2 * i] + frame[3 + 2 * i]);
    end
    if (frame.size() < 2 * n + 3) return;
    exp_outcome = (frame[2 * n + 2] == sum) ? 0 : 1;
  endtask

  task automatic run_frame(input string tag, input bit cont);
    int m;
    seen = {};
    model();
    foreach (frame[i]) begin
      send_byte(frame[i], cont ? 0 : int'($urandom_range(0, 3)));
      if (i == 0) chk({tag, ":busy_after_hdr"}, 32'(busy), 32'(1));
    end
    rx_valid = 1'b0;
    if (exp_outcome != 2) begin
      chk({tag, ":done"}, 32'(done), 32'(exp_outcome == 0));
      chk({tag, ":error"}, 32'(error), 32'(exp_outcome == 1));
      chk({tag, ":cpu_reset"}, 32'(cpu_reset), 32'(exp_outcome != 0));
      chk({tag, ":busy_end"}, 32'(busy), 32'(0));
    end
    chk({tag, ":nwrites"}, 32'(seen.size()), 32'(exp_q.size()));
    m = (seen.size() < exp_q.size()) ? seen.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      chk($sformatf("%s:w%0d", tag, i), 32'(seen[i]), 32'(exp_q[i]));
  endtask

  task automatic restart(input string tag);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk({tag, ":cpu_reset"}, 32'(cpu_reset), 32'(1));
    chk({tag, ":done_clr"}, 32'(done), 32'(0));
    chk({tag, ":error_clr"}, 32'(error), 32'(0));
    chk({tag, ":rx_ready"}, 32'(rx_ready), 32'(1));
  endtask

  task automatic wait_timeout(input string tag, input int expect_cycles);
    int cycles = 0;
    while (error !== 1'b1 && cycles < 40) begin
      tick(1);
      cycles++;
    end
    chk({tag, ":cycles"}, 32'(cycles), 32'(expect_cycles));
    chk({tag, ":cpu_reset"}, 32'(cpu_reset), 32'(1));
  endtask

  initial begin
    int n;
    logic [7:0] sum, b;
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    start = 1'b0;
    tick(2);
    chk("rst:im_we", 32'(im_we), 32'(0));
    chk("rst:im_d", 32'(im_d), 32'(0));
    chk("rst:im_address", 32'(im_address), 32'(0));
    chk("rst:cpu_reset", 32'(cpu_reset), 32'(1));
    chk("rst:busy", 32'(busy), 32'(0));
    chk("rst:done", 32'(done), 32'(0));
    chk("rst:error", 32'(error), 32'(0));
    chk("rst:rx_ready", 32'(rx_ready), 32'(1));
    reset = 1'b0;
    tick(1);

    frame = {8'h00, 8'h03, 8'h00, 8'h02, 8'hEC, 8'h10, 8'h00, 8'h17, 8'h15};
    run_frame("good3", 1'b0);
    chk("good3:model", 32'(exp_outcome), 32'(0));
    restart("rs1");
    frame = {8'h00, 8'h03, 8'h00, 8'h02, 8'hEC, 8'h10, 8'h00, 8'h17, 8'h16};
    run_frame("badsum", 1'b0);
    restart("rs2");
    frame = {8'h00, 8'h00, 8'h00};
    run_frame("empty", 1'b0);

    // From DONE: cpu_reset low until start, then a 25-word image
    chk("pre_start:cpu_reset", 32'(cpu_reset), 32'(0));
    restart("rs3");
    frame = {8'h00, 8'd25};
    sum = 8'd0;
    for (int i = 0; i < 50; i++) begin
      b = 8'($urandom);
      frame.push_back(b);
      sum = 8'(sum + b);
    end
    frame.push_back(sum);
    run_frame("img25", 1'b1);

    restart("rs4");
    frame = {8'h80, 8'h01};
    run_frame("toolong", 1'b0);

    restart("rs5");
    frame = {8'h80, 8'h00};
    run_frame("maxlen", 1'b0);
    chk("maxlen:error", 32'(error), 32'(0));
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("ign_start:busy", 32'(busy), 32'(1));
    chk("ign_start:cpu_reset", 32'(cpu_reset), 32'(1));
    wait_timeout("maxlen_to", int'(TO) - 1);

    restart("rs6");
    frame = {8'h00, 8'h02, 8'h12};
    run_frame("tmo", 1'b0);
    wait_timeout("tmo", int'(TO));
    chk("tmo:busy", 32'(busy), 32'(0));

    for (int k = 0; k < 4; k++) begin
      restart($sformatf("rr%0d", k));
      n = int'($urandom_range(1, 8));
      frame = {8'h00, 8'(n)};
      sum = 8'd0;
      for (int i = 0; i < 2 * n; i++) begin
        b = 8'($urandom);
        frame.push_back(b);
        sum = 8'(sum + b);
      end
      if ($urandom_range(0, 2) == 0) sum = sum ^ 8'(1 + $urandom_range(0, 254));
      frame.push_back(sum);
      run_frame($sformatf("rand%0d", k), k[0]);
    end

    // Reset mid-load, then a fresh frame with rx_valid held high throughout
    restart("rs7");
    seen = {};
    frame = {8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
    foreach (frame[i]) send_byte(frame[i], 0);
    reset = 1'b1;
    rx_valid = 1'b0;
    tick(1);
    chk("midrst:writes_before", 32'(seen.size()), 32'(2));
    chk("midrst:im_we", 32'(im_we), 32'(0));
    chk("midrst:busy", 32'(busy), 32'(0));
    chk("midrst:cpu_reset", 32'(cpu_reset), 32'(1));
    chk("midrst:rx_ready", 32'(rx_ready), 32'(1));
    reset = 1'b0;
    tick(1);
    frame = {8'h00, 8'h01, 8'hAB, 8'hCD, 8'h78};
    run_frame("after_rst", 1'b1);
    tick(3);
    chk("after_rst:no_extra", 32'(seen.size()), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Byte-stream bootloader directly upstream of instruction_memory and the cpu. It receives a framed program image over a byte valid/ready interface, typically from a UART receiver, and assembles 16-bit instruction words. It writes each word into instruction_memory through its write port (d / write_address / we). The cpu is held in reset until the whole image is loaded and its checksum verifies.

Parameters:
ADDR_WIDTH, 15, instruction memory address width; maximum image size is 2**ADDR_WIDTH words.
TIMEOUT_CYCLES, 1000000, idle cycles allowed between accepted bytes once a frame has started before the load is aborted.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
rx_data  input  8  incoming byte.
rx_valid  input  1  rx_data is valid.
rx_ready  output  1  loader can accept a byte; a transfer occurs on a clk edge where rx_valid && rx_ready.
start  input  1  single-cycle pulse requesting a reload; honoured only in DONE or ERROR.
im_d  output  16  instruction word to write.
im_address  output  ADDR_WIDTH  write address.
im_we  output  1  instruction memory write enable, one-cycle pulse per word.
cpu_reset  output  1  drives cpu.reset; high while not in DONE.
busy  output  1  a frame is in progress (first header byte accepted, checksum not yet resolved).
done  output  1  image loaded and verified.
error  output  1  load aborted: bad length, checksum mismatch or timeout.

Behaviour:
- Frame format: N_hi, N_lo (word count N, big-endian), then N words sent high byte first, then one checksum byte. The checksum is the sum mod 256 of the 2N payload bytes; header bytes are excluded.
- States: HDR_HI, HDR_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR.
- Reset: state=HDR_HI; outputs are im_we=0, im_d=0, im_address=0, cpu_reset=1, busy=0, done=0, error=0, rx_ready=1. Word counter, checksum accumulator and timeout counter are all cleared. Reset mid-load abandons the frame; nothing further is written.
- rx_ready=1 in HDR_HI, HDR_LO, DATA_HI, DATA_LO and CHECK; 0 in WRITE, DONE and ERROR.
- HDR_HI: on accept, latch N[15:8] and go to HDR_LO; busy=1 from the next cycle.
- HDR_LO: on accept, latch N[7:0].
  - N > 2**ADDR_WIDTH: go to ERROR.
  - N == 0: go to CHECK.
  - Otherwise: go to DATA_HI.
- DATA_HI: on accept, latch hi byte, add it to the checksum, go to DATA_LO.
- DATA_LO: on accept, add the byte to the checksum and go to WRITE. During the WRITE cycle: im_we=1, im_d={hi,lo}, im_address=word index (registered outputs). Addresses start at 0 and increment by 1 per word. The address never wraps, because N is capped by the HDR_LO check.
- WRITE (exactly one cycle): if this was word N-1, go to CHECK; otherwise go to DATA_HI. Upstream holding rx_valid during WRITE is legal; the byte is accepted the following cycle.
- CHECK: on accept, compare the byte to the accumulated checksum. Equal: go to DONE. Not equal: go to ERROR. Words already written remain in memory.
- DONE: done=1, cpu_reset=0, busy=0. Both take effect on the first cycle after the checksum byte is accepted.
- ERROR: error=1, cpu_reset=1, busy=0.
- start in DONE or ERROR: clear done/error, set cpu_reset=1 and clear counters on the next edge, go to HDR_HI. start in any other state is ignored.
- Timeout: the counter resets on every accepted byte and counts in HDR_LO, DATA_HI, DATA_LO and CHECK. When it reaches TIMEOUT_CYCLES, go to ERROR. There is no timeout in HDR_HI.
- im_we is 0 in every state other than WRITE.

Test Plan:
- Load 3 words, bytes 00 03 00 02 EC 10 00 17 15 -> im_we pulses write 0x0002@0, 0xEC10@1, 0x0017@2; then done=1, cpu_reset=0, error=0; cpu fetches 0x0002 at pc=0.
- Same frame with checksum byte 0x16 -> all three words written, error=1, done=0, cpu_reset stays 1.
- Frame 00 00 00 -> no im_we pulses, done=1. Header 80 01 -> error immediately after the second byte, no writes.
- Send 00 02 12, then hold rx_valid=0 with TIMEOUT_CYCLES=16 -> error=1 exactly 16 cycles after the last accepted byte.
- In DONE, pulse start, then send the full 25-word image with a correct checksum -> cpu_reset rises the cycle after start; 25 writes at addresses 0..24; done=1 again.
- Assert reset after the 4th data byte, then send a fresh 1-word frame 00 01 AB CD 78 -> only 0xABCD@0 is written after reset, done=1. Hold rx_valid=1 continuously and verify no byte is lost across WRITE cycles.
